// File: rtl/dsp_batch_controller.sv
// Instruction-FIFO fed sequencer for the BRAM0/BRAM1 -> DSP48 -> BRAM1 datapath.
// Each instruction runs rep+1 elements of READ / EXE x DSP_LATENCY / WRITE with auto-incremented indices.
module dsp_batch_controller #(
    parameter int DSP_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 10,
    parameter int IDX_W       = 5,
    parameter int REP_W       = 4,
    parameter int INST_W      = 3*IDX_W + REP_W + 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INST_W-1:0]             inst,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]             bram0_raddrb,
    output logic                          bram0_enb,
    output logic [ADDR_W-1:0]             bram1_addrb,
    output logic [3:0]                    bram1_web,
    output logic                          bram1_enb,
    output logic [4:0]                    dsp_inmode,
    output logic [6:0]                    dsp_opmode,
    output logic [3:0]                    dsp_alumode
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int LAT_W    = $clog2(DSP_LATENCY + 1);
    localparam int OFS_SRC1 = IDX_W;
    localparam int OFS_DST  = 2*IDX_W;
    localparam int OFS_INM  = 3*IDX_W;
    localparam int OFS_OPM  = OFS_INM + 5;
    localparam int OFS_ALU  = OFS_OPM + 7;
    localparam int OFS_REP  = OFS_ALU + 4;
    localparam int OFS_EXEC = OFS_REP + REP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [INST_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [INST_W-1:0]   head;
    logic [INST_W-2:0]   inst_reg;
    logic [REP_W-1:0]    iter_reg, iter_next;
    logic [LAT_W-1:0]    lat_reg, lat_next;
    logic                push, pop, fifo_empty, write_cycle;

    logic [IDX_W-1:0]    src0_f, src1_f, dst_f;
    logic [REP_W-1:0]    rep_f;
    logic [IDX_W-1:0]    rd0_idx, rd1_idx, wr_idx;

    assign fifo_empty = (count_reg == '0);
    assign inst_ready = (count_reg < CNT_W'(FIFO_DEPTH));
    assign fifo_count = count_reg;
    assign busy       = (state_reg != S_IDLE) || !fifo_empty;

    // Abort outranks both sides of the FIFO: a same-cycle push is dropped and nothing is popped.
    assign push = inst_valid && inst_ready && !abort;
    assign pop  = (state_reg == S_IDLE) && !fifo_empty && !abort;
    assign head = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // State register and per-instruction datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            inst_reg  <= '0;
            iter_reg  <= '0;
            lat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
            lat_reg   <= lat_next;
            if (pop) inst_reg <= head[INST_W-2:0];
        end
    end

    assign src0_f = inst_reg[OFS_SRC1-1:0];
    assign src1_f = inst_reg[OFS_DST-1:OFS_SRC1];
    assign dst_f  = inst_reg[OFS_INM-1:OFS_DST];
    assign rep_f  = inst_reg[OFS_EXEC-1:OFS_REP];

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        lat_next   = lat_reg;
        if (abort) begin
            state_next = S_IDLE;
            iter_next  = '0;
            lat_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        iter_next  = '0;
                        state_next = head[OFS_EXEC] ? S_READ : S_DONE;
                    end
                end
                S_READ:  state_next = S_EXE;
                S_EXE: begin
                    if (lat_reg == LAT_W'(DSP_LATENCY - 1)) begin
                        lat_next   = '0;
                        state_next = S_WRITE;
                    end else begin
                        lat_next = lat_reg + LAT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (iter_reg == rep_f) begin
                        state_next = S_DONE;
                    end else begin
                        iter_next  = iter_reg + REP_W'(1);
                        state_next = S_READ;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Index sums are kept IDX_W wide so they wrap before zero-extension.
    assign rd0_idx = src0_f + IDX_W'(iter_reg);
    assign rd1_idx = src1_f + IDX_W'(iter_reg);
    assign wr_idx  = dst_f  + IDX_W'(iter_reg);

    always_comb begin
        done         = 1'b0;
        bram0_enb    = 1'b0;
        bram0_raddrb = '0;
        bram1_enb    = 1'b0;
        bram1_addrb  = '0;
        write_cycle  = 1'b0;
        dsp_inmode   = '0;
        dsp_opmode   = '0;
        dsp_alumode  = '0;
        case (state_reg)
            S_READ: begin
                bram0_enb    = 1'b1;
                bram0_raddrb = ADDR_W'(rd0_idx);
                bram1_enb    = 1'b1;
                bram1_addrb  = ADDR_W'(rd1_idx);
            end
            S_EXE: begin
                dsp_inmode  = inst_reg[OFS_OPM-1:OFS_INM];
                dsp_opmode  = inst_reg[OFS_ALU-1:OFS_OPM];
                dsp_alumode = inst_reg[OFS_REP-1:OFS_ALU];
            end
            S_WRITE: begin
                bram1_enb   = 1'b1;
                bram1_addrb = ADDR_W'(wr_idx);
                write_cycle = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_web
            assign bram1_web[gi] = write_cycle;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_batch_controller.sv
// Scoreboard bench: each accepted instruction expands into its expected output events,
// and a negedge monitor pops and compares every active output cycle, including cycle spacing.
module tb_dsp_batch_controller;

    localparam int LAT  = 3;
    localparam int IDX  = 5;
    localparam int REPW = 4;
    localparam int AW   = 10;
    localparam int IW   = 3*IDX + REPW + 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] inst = '0;
    logic          inst_valid = 1'b0;
    logic          abort = 1'b0;
    logic          inst_ready, busy, done, bram0_enb, bram1_enb;
    logic [2:0]    fifo_count;
    logic [AW-1:0] bram0_raddrb, bram1_addrb;
    logic [3:0]    bram1_web, dsp_alumode;
    logic [4:0]    dsp_inmode;
    logic [6:0]    dsp_opmode;

    dsp_batch_controller #(
        .DSP_LATENCY(LAT), .FIFO_DEPTH(4), .ADDR_W(AW), .IDX_W(IDX), .REP_W(REPW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .abort(abort), .busy(busy), .done(done),
        .fifo_count(fifo_count), .bram0_raddrb(bram0_raddrb), .bram0_enb(bram0_enb),
        .bram1_addrb(bram1_addrb), .bram1_web(bram1_web), .bram1_enb(bram1_enb),
        .dsp_inmode(dsp_inmode), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [42:0] vec;
        int          gap;   // required cycles since previous active cycle, 0 = unchecked
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  n_checks = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  n_push = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [42:0] pk(input logic d, input logic b0e, input logic [9:0] b0a,
                                       input logic b1e, input logic [9:0] b1a, input logic [3:0] we,
                                       input logic [4:0] im, input logic [6:0] om, input logic [3:0] am);
        return {d, b0e, b0a, b1e, b1a, we, im, om, am};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
        end
    endtask

    // Reference model: an instruction is rep+1 elements, each READ, LAT EXE cycles, WRITE; then one done.
    task automatic model_push(input int e, input int r, input int s0, input int s1, input int d,
                              input int im, input int om, input int am, input int first_gap);
        ev_t ev;
        if (e == 0) begin
            ev.vec = pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
            ev.gap = first_gap;
            exp_q.push_back(ev);
            return;
        end
        for (int i = 0; i <= r; i++) begin
            ev.vec = pk(0, 1, 10'((s0 + i) % 32), 1, 10'((s1 + i) % 32), 0, 0, 0, 0);
            ev.gap = (i == 0) ? first_gap : 1;
            exp_q.push_back(ev);
            for (int k = 0; k < LAT; k++) begin
                ev.vec = pk(0, 0, 0, 0, 0, 0, 5'(im), 7'(om), 4'(am));
                ev.gap = 1;
                exp_q.push_back(ev);
            end
            ev.vec = pk(0, 0, 0, 1, 10'((d + i) % 32), 4'hF, 0, 0, 0);
            ev.gap = 1;
            exp_q.push_back(ev);
        end
        ev.vec = pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        ev.gap = 1;
        exp_q.push_back(ev);
    endtask

    // Offers one instruction from posedge+1 until accepted; returns at posedge+1 of the accept edge.
    task automatic send(input int e, input int r, input int s0, input int s1, input int d,
                        input int im, input int om, input int am, input int first_gap);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        inst = {1'(e), 4'(r), 4'(am), 7'(om), 5'(im), 5'(d), 5'(s1), 5'(s0)};
        inst_valid = 1'b1;
        for (int t = 0; t < 500 && !accepted; t++) begin
            @(negedge clk);
            rdy = inst_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        inst_valid = 1'b0;
        if (accepted) begin
            n_push++;
            $display("push %0d: exec=%0d rep=%0d src0=%0d src1=%0d dst=%0d cycle=%0d",
                     n_push, e, r, s0, s1, d, cyc);
            model_push(e, r, s0, s1, d, im, om, am, first_gap);
        end else begin
            n_checks++;
            errors++;
            $display("FAIL push_timeout: got=not_accepted expected=accepted");
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b0 | 1'b1;
        end
        chk("drain", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with any active output must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [42:0] obs;
        ev_t ev;
        if (rst_n) begin
            obs = pk(done, bram0_enb, bram0_raddrb, bram1_enb, bram1_addrb, bram1_web,
                     dsp_inmode, dsp_opmode, dsp_alumode);
            if (obs != '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got=%0h expected=none at cycle %0d", obs, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (obs !== ev.vec) begin
                        errors++;
                        $display("FAIL output_event: got=%0h expected=%0h at cycle %0d", obs, ev.vec, cyc);
                    end
                    if (ev.gap != 0) begin
                        n_checks++;
                        if (cyc - last_cyc != ev.gap) begin
                            errors++;
                            $display("FAIL event_spacing: got=%0d expected=%0d at cycle %0d",
                                     cyc - last_cyc, ev.gap, cyc);
                        end
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic hit;

        // Reset values
        #3;
        chk("reset_ready", inst_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_outputs", pk(done, bram0_enb, bram0_raddrb, bram1_enb, bram1_addrb, bram1_web,
                                dsp_inmode, dsp_opmode, dsp_alumode), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scalar operation with first-READ timing
        send(1, 0, 3, 4, 7, 5'h11, 7'h35, 4'h3, 0);
        @(negedge clk);
        chk("pop_cycle_enb", bram0_enb, 0);
        chk("pop_cycle_count", fifo_count, 1);
        chk("pop_cycle_busy", busy, 1);
        @(negedge clk);
        chk("first_read_enb", bram0_enb, 1);
        chk("first_read_addr", bram0_raddrb, 3);
        wait_idle();

        // Vector with index wrap
        send(1, 3, 30, 0, 31, 5'h05, 7'h12, 4'h1, 0);
        wait_idle();

        // NOP followed immediately by an exec instruction
        send(0, 0, 1, 2, 3, 5'h01, 7'h01, 4'h1, 0);
        send(1, 1, 9, 10, 11, 5'h1F, 7'h7F, 4'hF, 2);
        wait_idle();

        // FIFO full with a long instruction in flight
        send(1, 15, 2, 4, 6, 5'h02, 7'h44, 4'h2, 0);
        send(1, 0, 1, 1, 1, 5'h03, 7'h01, 4'h1, 2);
        send(1, 1, 2, 2, 2, 5'h04, 7'h02, 4'h2, 2);
        send(1, 0, 3, 3, 3, 5'h05, 7'h03, 4'h3, 2);
        send(0, 0, 4, 4, 4, 5'h06, 7'h04, 4'h4, 2);
        chk("full_count", fifo_count, 4);
        chk("full_ready", inst_ready, 0);
        t0 = cyc;
        send(1, 0, 5, 5, 5, 5'h07, 7'h05, 4'h5, 2);
        chk("fifth_waited", {63'd0, (cyc - t0) > 60}, 1);
        chk("refill_count", fifo_count, 4);
        wait_idle();

        // Abort during EXE with two queued; a same-cycle push must be dropped
        send(1, 2, 8, 9, 10, 5'h09, 7'h09, 4'h9, 0);
        send(1, 0, 1, 2, 3, 5'h0A, 7'h0A, 4'hA, 2);
        send(1, 0, 4, 5, 6, 5'h0B, 7'h0B, 4'hB, 2);
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            if (dsp_inmode != 0) hit = 1'b1;
        end
        chk("abort_reached_exe", {63'd0, hit}, 1);
        abort = 1'b1;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        inst_valid = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_count", fifo_count, 0);
        chk("abort_ready", inst_ready, 1);
        repeat (30) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a WRITE cycle
        send(1, 1, 12, 13, 14, 5'h0C, 7'h0C, 4'hC, 0);
        send(1, 0, 1, 1, 1, 5'h0D, 7'h0D, 4'hD, 2);
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            if (bram1_web != 0) hit = 1'b1;
        end
        chk("reset_reached_write", {63'd0, hit}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_web", bram1_web, 0);
        chk("midrst_enables", {bram0_enb, bram1_enb}, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", inst_ready, 1);
        chk("post_rst_count", fifo_count, 0);
        send(1, 0, 3, 4, 7, 5'h11, 7'h35, 4'h3, 0);
        wait_idle();

        // Randomised stream
        for (int n = 0; n < 25; n++) begin
            send(($urandom_range(0, 5) != 0) ? 1 : 0, $urandom_range(0, 3),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(1, 31), $urandom_range(0, 127), $urandom_range(0, 15), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dsp_batch_controller.md
Name: dsp_batch_controller

Overview:
Next-generation sequencer for the BRAM0/BRAM1 → DSP48 → BRAM1 datapath. It accepts instructions through a valid/ready port into an internal instruction FIFO. Each instruction executes as a vector of up to 2^REP_W element operations, with source and destination addresses auto-incremented per element. It drives the BRAM port-B controls and the DSP mode buses, reports busy, and pulses done once per retired instruction.

Parameters:
DSP_LATENCY, 3, cycles the DSP mode buses are held per element (>=1).
FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
ADDR_W, 10, BRAM address width.
IDX_W, 5, operand index field width (<=ADDR_W).
REP_W, 4, repeat-count field width.
INST_W, 3*IDX_W+REP_W+17, derived instruction width; do not override.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
inst  in  INST_W  instruction. Fields LSB-first: src0[IDX_W], src1[IDX_W], dst[IDX_W], inmode[5], opmode[7], alumode[4], rep[REP_W], exec[1] (MSB).
inst_valid  in  1  instruction offered.
inst_ready  out  1  FIFO can accept (count < FIFO_DEPTH).
abort  in  1  synchronous flush of the FIFO and the current instruction.
busy  out  1  state != IDLE or FIFO non-empty.
done  out  1  one-cycle pulse, one instruction retired.
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
bram0_raddrb  out  ADDR_W  BRAM0 read address.
bram0_enb  out  1  BRAM0 enable.
bram1_addrb  out  ADDR_W  BRAM1 address.
bram1_web  out  4  BRAM1 byte write enables.
bram1_enb  out  1  BRAM1 enable.
dsp_inmode  out  5  DSP INMODE.
dsp_opmode  out  7  DSP OPMODE.
dsp_alumode  out  4  DSP ALUMODE.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, state IDLE, iteration and latency counters 0.
- Output values in reset: all outputs 0 except inst_ready=1.
- Push: occurs when inst_valid && inst_ready at a clk edge. inst_ready is combinational from fifo_count, so there is no push while full.
- Simultaneous push and pop: allowed whenever the FIFO is not full. Count is then unchanged.
- FSM states: IDLE, READ, EXE, WRITE, DONE.
- Outputs are a combinational decode of state and registered fields. The DSP buses and the BRAM address/enable outputs are 0 in any state where they are not driven below.
- IDLE:
  - FIFO non-empty → pop head into inst_reg, iter<=0.
  - Next state READ if exec=1; DONE if exec=0 (NOP, no BRAM or DSP activity).
  - An entry pushed into an empty FIFO is popped on the following edge, so the earliest READ is 2 cycles after the push edge.
- READ (1 cycle):
  - bram0_enb=1, bram0_raddrb = zero-extended (src0+iter) mod 2^IDX_W.
  - bram1_enb=1, bram1_web=0, bram1_addrb = zero-extended (src1+iter) mod 2^IDX_W.
- EXE (exactly DSP_LATENCY cycles):
  - dsp_inmode/opmode/alumode = inst_reg fields.
  - Latency counter runs 0..DSP_LATENCY-1, clears on exit.
- WRITE (1 cycle):
  - bram1_enb=1, bram1_web=4'hF, bram1_addrb = zero-extended (dst+iter) mod 2^IDX_W.
  - If iter==rep → DONE; else iter<=iter+1 → READ.
- DONE (1 cycle): done=1, then → IDLE.
- Element timing:
  - Each element takes DSP_LATENCY+2 cycles.
  - An instruction occupies 1 (IDLE pop) + (rep+1)*(DSP_LATENCY+2) + 1 cycles.
- Address wrap: index arithmetic wraps modulo 2^IDX_W. Upper ADDR_W-IDX_W bits are always 0.
- rep=0: single element, identical timing to a scalar operation.
- Abort, sampled at the edge:
  - FIFO cleared, state → IDLE, iter and latency counters cleared.
  - No done pulse for the aborted instruction.
  - A push in the same cycle is dropped.
  - If abort is sampled during WRITE, that cycle's write still occurs, because outputs decode the current state.
- Reset mid-operation: outputs drop to reset values immediately and asynchronously. No partial write completes after rst_n falls.

Test Plan:
- Scalar: push {exec=1, rep=0, src0=3, src1=4, dst=7}, DSP_LATENCY=3.
  - READ: bram0_raddrb=3, bram1_addrb=4.
  - 3 EXE cycles with the mode fields driven.
  - WRITE: bram1_addrb=7, web=F.
  - done exactly 1 cycle after WRITE.
- Vector with wrap: rep=3, src0=30, src1=0, dst=31.
  - READ addresses src0 30,31,0,1 and src1 0,1,2,3.
  - Writes to 31,0,1,2.
  - One done pulse, 22 cycles from the pop edge through the done cycle.
- NOP and back-to-back:
  - Push exec=0 then exec=1 on consecutive cycles.
  - NOP gives done with no enables asserted; second instruction's READ starts in the cycle after the first done+IDLE.
- FIFO full: push 5 instructions while busy with FIFO_DEPTH=4.
  - inst_ready falls at fifo_count=4; 5th accepted only after the next pop.
  - Execution order matches push order.
- Abort during EXE with 2 queued:
  - Next cycle: state IDLE, fifo_count=0, busy=0.
  - No WRITE and no done for the aborted instruction.
- Async reset asserted mid-WRITE, between clock edges:
  - bram1_web=0, enables=0, done=0 immediately.
  - After release, inst_ready=1 and FIFO is empty.
